// File: rtl/score_pkg.sv
// Shared types and widths for the score keeper block.
package score_pkg;

  localparam int SCORE_W = 3;
  localparam int MISS_W  = 2;

  // Event lane indices into the edge-detector array
  localparam int EV_START = 0;
  localparam int EV_HIT   = 1;
  localparam int EV_MISS  = 2;
  localparam int NUM_EV   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_e;

endpackage

// File: rtl/score_keeper_edge_det.sv
// Registered rising-edge detector (module edge_det).
// A level already high when reset releases is swallowed: the first cycle
// out of reset only arms the detector and captures the level.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic ev
);

  logic x_q;
  logic armed;

  // One-cycle copy of the input plus the post-reset arm flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      x_q   <= x;
      armed <= 1'b1;
    end
  end

  assign ev = x & ~x_q & armed;

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: counts hits and misses during play, declares win/lose.
// Optional macro SCORE_KEEPER_BLINK_EN makes win blink with a half-period of
// BLINK_DIV cycles; without it win is steady and no blink counter exists.
module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE  = 7,
  parameter int MAX_MISSES = 3,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic               playing,
  output logic               win,
  output logic               lose
);

  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(WIN_SCORE - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MAX_MISSES - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 7 || MAX_MISSES < 1 || MAX_MISSES > 3 ||
      BLINK_DIV < 1) begin : g_bad_param
    $error("score_keeper: parameter out of range");
  end

  logic [NUM_EV-1:0] raw;
  logic [NUM_EV-1:0] ev;
  state_e            state;
  logic              win_entry;
  logic              win_hold;

  assign raw = {miss, hit, start};

  for (genvar g = 0; g < NUM_EV; g++) begin : g_ed
    edge_det u_ed (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (raw[g]),
      .ev    (ev[g])
    );
  end

  // Final point lands this edge; stay in WIN until a start event
  assign win_entry = (state == PLAY) && ev[EV_HIT] && (score == SCORE_LAST);
  assign win_hold  = (state == WIN) && !ev[EV_START];

  // Game FSM with registered score/miss counters and status flags.
  // In PLAY the counters stay below their limits, so +1 never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      score   <= '0;
      misses  <= '0;
      playing <= 1'b0;
      lose    <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (ev[EV_HIT]) begin
            score <= score + 1'b1;
            if (score == SCORE_LAST) begin
              state   <= WIN;
              playing <= 1'b0;
            end
          end else if (ev[EV_MISS]) begin
            misses <= misses + 1'b1;
            if (misses == MISS_LAST) begin
              state   <= LOSE;
              playing <= 1'b0;
              lose    <= 1'b1;
            end
          end
        end
        IDLE, WIN, LOSE: begin
          if (ev[EV_START]) begin
            state   <= PLAY;
            score   <= '0;
            misses  <= '0;
            playing <= 1'b1;
            lose    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_KEEPER_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] blink_cnt;

  // Win blinks: on at entry, toggles every BLINK_DIV cycles while in WIN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      win       <= 1'b0;
    end else if (win_entry) begin
      blink_cnt <= '0;
      win       <= 1'b1;
    end else if (win_hold) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        win       <= ~win;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      win       <= 1'b0;
    end
  end
`else
  // Win is a steady flag for the whole WIN state
  always_ff @(posedge clk) begin
    if (!rst_n) win <= 1'b0;
    else        win <= win_entry | win_hold;
  end
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper (BLINK_DIV overridden to 4).
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, hit, miss;
  logic [2:0] score;
  logic [1:0] misses;
  logic       playing, win, lose;

  int nvec = 0;
  int nerr = 0;

  score_keeper #(.WIN_SCORE(7), .MAX_MISSES(3), .BLINK_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .hit     (hit),
    .miss    (miss),
    .score   (score),
    .misses  (misses),
    .playing (playing),
    .win     (win),
    .lose    (lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int s, input int m,
                         input int p, input int w, input int l);
    chk({tag, ".score"},   score,   s);
    chk({tag, ".misses"},  misses,  m);
    chk({tag, ".playing"}, playing, p);
    chk({tag, ".win"},     win,     w);
    chk({tag, ".lose"},    lose,    l);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1; tick();

    // Hits in IDLE are ignored
    hit = 1'b1; tick(); hit = 1'b0; tick();
    chk("idle_hit.score", score, 0);

    start = 1'b1; tick();
    chk_all("start", 0, 0, 1, 0, 0);
    start = 1'b0; tick();

    // Seven hits to a win
    for (int i = 1; i <= 7; i++) begin
      hit = 1'b1; tick();
      chk($sformatf("hit%0d.score", i), score, i);
      chk($sformatf("hit%0d.playing", i), playing, (i < 7) ? 1 : 0);
      chk($sformatf("hit%0d.win", i), win, (i == 7) ? 1 : 0);
      hit = 1'b0;
      if (i < 7) tick();
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
`ifdef SCORE_KEEPER_BLINK_EN
      chk($sformatf("blink%0d", k), win, ((k / 4) % 2 == 0) ? 1 : 0);
`else
      chk($sformatf("winsteady%0d", k), win, 1);
`endif
    end
    hit = 1'b1; tick(); hit = 1'b0; tick();
    chk("win_hit.score", score, 7);

    // Restart from WIN
    start = 1'b1; tick();
    chk_all("restart_win", 0, 0, 1, 0, 0);
    start = 1'b0; tick();

    // One hit, then three misses to lose
    hit = 1'b1; tick(); hit = 1'b0; tick();
    for (int i = 1; i <= 3; i++) begin
      miss = 1'b1; tick();
      chk($sformatf("miss%0d.misses", i), misses, i);
      chk($sformatf("miss%0d.lose", i), lose, (i == 3) ? 1 : 0);
      chk($sformatf("miss%0d.score", i), score, 1);
      miss = 1'b0; tick();
    end
    chk("lose.playing", playing, 0);
    hit = 1'b1; tick(); hit = 1'b0; tick();
    miss = 1'b1; tick(); miss = 1'b0; tick();
    chk_all("lose_ignore", 1, 3, 0, 0, 1);

    // Held level counts once; simultaneous hit+miss keeps only the hit
    pulse_start();
    chk_all("restart_lose", 0, 0, 1, 0, 0);
    hit = 1'b1;
    repeat (20) tick();
    chk("held_hit.score", score, 1);
    hit = 1'b0; tick();
    hit = 1'b1; miss = 1'b1; tick();
    chk("both.score", score, 2);
    chk("both.misses", misses, 0);
    hit = 1'b0; miss = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin
      hit = 1'b1; tick(); hit = 1'b0; tick();
    end
    chk("mid.score", score, 4);

    // Reset mid-game with hit and start held across release
    rst_n = 1'b0; hit = 1'b1; start = 1'b1; tick();
    chk_all("midrst", 0, 0, 0, 0, 0);
    rst_n = 1'b1; tick(); tick(); tick();
    chk_all("post_rst", 0, 0, 0, 0, 0);
    hit = 1'b0; start = 1'b0; tick();
    pulse_start();
    chk("post_rst_start.playing", playing, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
